// File: rtl/csr_trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl_pkg
// Shared definitions for the machine-mode trap sequencer:
//   - CSR addresses written by the trap / mret sequences
//   - interrupt cause codes (interrupt bit set)
//   - mstatus / mie bit positions
//   - sequencer state encoding
//   - helpers computing the mstatus values written on trap entry / mret,
//     and the trap handler target address
// ---------------------------------------------------------------------------
package csr_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [31:0] CAUSE_IRQ_SW  = 32'h8000_0003;
    localparam logic [31:0] CAUSE_IRQ_TMR = 32'h8000_0007;
    localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIE_MSIE = 3;
    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MTVAL   = 3'd3,
        ST_W_MSTATUS = 3'd4,
        ST_MRET      = 3'd5,
        ST_JUMP      = 3'd6
    } trap_state_e;

    // Trap entry: stash MIE in MPIE, disable interrupts, previous mode = M.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MSTATUS_MPIE] = m[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // mret: restore MIE from MPIE, re-arm MPIE, stay in M.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Handler address. Only interrupts are vectored; 4*cause[30:0] modulo
    // 2^32 reduces to cause[29:0] shifted by two.
    function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                                input logic [29:0] cause_lo,
                                                input logic        is_irq,
                                                input logic        vec_en);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (vec_en && (mtvec[1:0] == 2'b01) && is_irq)
            return base + {cause_lo, 2'b00};
        return base;
    endfunction

endpackage

// File: rtl/csr_trap_ctrl_trap_prio.sv
// ---------------------------------------------------------------------------
// trap_prio
// Combinational interrupt priority encoder. An interrupt is eligible when
// global MIE is set, its line is high and its enable bit is set.
// Priority: external > software > timer.
// Ports:
//   irq_ext, irq_sw, irq_tmr   level interrupt lines
//   mstatus_mie                mstatus.MIE
//   mie_meie, mie_msie, mie_mtie  per-source enables from mie
//   irq_valid                  some interrupt is eligible
//   irq_cause                  mcause value of the winning interrupt
// ---------------------------------------------------------------------------
module trap_prio
    import csr_trap_ctrl_pkg::*;
(
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic        irq_tmr,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_msie,
    input  logic        mie_mtie,
    output logic        irq_valid,
    output logic [31:0] irq_cause
);

    logic ext_ok;
    logic sw_ok;
    logic tmr_ok;

    assign ext_ok = mstatus_mie && irq_ext && mie_meie;
    assign sw_ok  = mstatus_mie && irq_sw  && mie_msie;
    assign tmr_ok = mstatus_mie && irq_tmr && mie_mtie;

    always_comb begin
        irq_valid = 1'b0;
        irq_cause = '0;
        if (ext_ok) begin
            irq_valid = 1'b1;
            irq_cause = CAUSE_IRQ_EXT;
        end else if (sw_ok) begin
            irq_valid = 1'b1;
            irq_cause = CAUSE_IRQ_SW;
        end else if (tmr_ok) begin
            irq_valid = 1'b1;
            irq_cause = CAUSE_IRQ_TMR;
        end
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
// Machine-mode trap sequencer and CSR write-port arbiter in front of csr_reg.
// Accepts exceptions, interrupts and mret in IDLE, then drives the
// mepc/mcause/mtval/mstatus updates one per cycle through the single CSR
// write port and finishes with a one-cycle pipeline redirect. In IDLE with
// nothing accepted the CSR-instruction write port passes straight through.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   exc_req_i/cause/tval/pc       synchronous exception from execute
//   mret_i                        mret in execute
//   irq_ext_i/sw_i/tmr_i          level interrupt lines
//   next_pc_i                     mepc value for interrupts
//   mstatus_i/mie_i/mtvec_i/mepc_i  current CSR values
//   inst_csr_we/waddr/wdata_i     CSR-instruction write port
//   csr_we/waddr/wdata_o          write port to csr_reg
//   stall_o                       hold the pipeline
//   jump_o, jump_addr_o           one-cycle redirect and its target
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | passthrough; accept exception > interrupt > mret
// ST_W_MEPC    | write mepc with the latched return PC
// ST_W_MCAUSE  | write mcause
// ST_W_MTVAL   | write mtval (0 for interrupts)
// ST_W_MSTATUS | write trap-entry mstatus
// ST_MRET      | write mret mstatus
// ST_JUMP      | redirect to handler or latched mepc
// ---------------------------------------------------------------------------
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter bit MTVEC_VEC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req_i,
    input  logic [31:0] exc_cause_i,
    input  logic [31:0] exc_tval_i,
    input  logic [31:0] exc_pc_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_sw_i,
    input  logic        irq_tmr_i,
    input  logic [31:0] next_pc_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        inst_csr_we_i,
    input  logic [11:0] inst_csr_waddr_i,
    input  logic [31:0] inst_csr_wdata_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        stall_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    trap_state_e state_q;
    trap_state_e state_d;

    logic [31:0] cause_q;
    logic [31:0] tval_q;
    logic [31:0] epc_q;
    logic [31:0] mstatus_q;
    logic [31:0] mtvec_q;
    logic [29:0] ret_pc_q;
    logic        is_irq_q;
    logic        is_mret_q;

    logic        irq_valid;
    logic [31:0] irq_cause;
    logic        accept_exc;
    logic        accept_irq;
    logic        accept_mret;

    // Only mie bits 3/7/11 and mepc[31:2] matter here.
    logic unused_inputs;
    assign unused_inputs = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4],
                             mie_i[2:0], mepc_i[1:0]};

    trap_prio u_trap_prio (
        .irq_ext     (irq_ext_i),
        .irq_sw      (irq_sw_i),
        .irq_tmr     (irq_tmr_i),
        .mstatus_mie (mstatus_i[MSTATUS_MIE]),
        .mie_meie    (mie_i[MIE_MEIE]),
        .mie_msie    (mie_i[MIE_MSIE]),
        .mie_mtie    (mie_i[MIE_MTIE]),
        .irq_valid   (irq_valid),
        .irq_cause   (irq_cause)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cause_q   <= '0;
            tval_q    <= '0;
            epc_q     <= '0;
            mstatus_q <= '0;
            mtvec_q   <= '0;
            ret_pc_q  <= '0;
            is_irq_q  <= 1'b0;
            is_mret_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_exc || accept_irq) begin
                cause_q   <= accept_exc ? exc_cause_i : irq_cause;
                tval_q    <= accept_exc ? exc_tval_i  : '0;
                epc_q     <= accept_exc ? exc_pc_i    : next_pc_i;
                mstatus_q <= mstatus_i;
                mtvec_q   <= mtvec_i;
                ret_pc_q  <= mepc_i[31:2];
                is_irq_q  <= accept_irq;
                is_mret_q <= 1'b0;
            end else if (accept_mret) begin
                mstatus_q <= mstatus_i;
                mtvec_q   <= mtvec_i;
                ret_pc_q  <= mepc_i[31:2];
                is_irq_q  <= 1'b0;
                is_mret_q <= 1'b1;
            end
        end
    end

    // Outputs are decoded from the state so the writes land in the cycles
    // T+1..T+4. While rst is high everything is forced to its reset value,
    // so a reset mid-sequence suppresses the write of that cycle too.
    always_comb begin
        state_d     = state_q;
        accept_exc  = 1'b0;
        accept_irq  = 1'b0;
        accept_mret = 1'b0;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        stall_o     = 1'b0;
        jump_o      = 1'b0;
        jump_addr_o = '0;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (exc_req_i) begin
                        accept_exc = 1'b1;
                        state_d    = ST_W_MEPC;
                    end else if (irq_valid && !inst_csr_we_i) begin
                        // A pending interrupt waits for the cycle without an
                        // instruction CSR write so that write is not lost.
                        accept_irq = 1'b1;
                        state_d    = ST_W_MEPC;
                    end else if (mret_i) begin
                        accept_mret = 1'b1;
                        state_d     = ST_MRET;
                    end
                    if (state_d != ST_IDLE) begin
                        stall_o = 1'b1;
                    end else begin
                        csr_we_o    = inst_csr_we_i;
                        csr_waddr_o = inst_csr_waddr_i;
                        csr_wdata_o = inst_csr_wdata_i;
                    end
                end
                ST_W_MEPC: begin
                    stall_o     = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MEPC;
                    csr_wdata_o = epc_q;
                    state_d     = ST_W_MCAUSE;
                end
                ST_W_MCAUSE: begin
                    stall_o     = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MCAUSE;
                    csr_wdata_o = cause_q;
                    state_d     = ST_W_MTVAL;
                end
                ST_W_MTVAL: begin
                    stall_o     = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MTVAL;
                    csr_wdata_o = tval_q;
                    state_d     = ST_W_MSTATUS;
                end
                ST_W_MSTATUS: begin
                    stall_o     = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    csr_wdata_o = mstatus_on_trap(mstatus_q);
                    state_d     = ST_JUMP;
                end
                ST_MRET: begin
                    stall_o     = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    csr_wdata_o = mstatus_on_mret(mstatus_q);
                    state_d     = ST_JUMP;
                end
                ST_JUMP: begin
                    stall_o = 1'b1;
                    jump_o  = 1'b1;
                    if (is_mret_q)
                        jump_addr_o = {ret_pc_q, 2'b00};
                    else
                        jump_addr_o = trap_target(mtvec_q, cause_q[29:0],
                                                  is_irq_q, MTVEC_VEC_EN);
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule
